// File: rtl/mux3_rr_sel_pkg.sv
// Purpose : shared types, select codes and arbitration helpers for mux3_rr_sel.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
package mux3_rr_sel_pkg;

   // Two-bit state register: IDLE plus one grant state per source.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2,
      G2   = 2'd3
   } state_t;

   // Mux select codes; 2'b11 is never driven.
   localparam logic [1:0] SEL_D0 = 2'b00;
   localparam logic [1:0] SEL_D1 = 2'b01;
   localparam logic [1:0] SEL_D2 = 2'b10;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } pick_t;

   // Scan (last+1)%3, (last+2)%3, last; first asserted request wins.
   // The previous owner is therefore only picked when it is the sole requester.
   function automatic pick_t next_req(input logic [1:0] last, input logic [2:0] req);
      pick_t      p;
      logic [1:0] c;
      p.found = 1'b0;
      p.idx   = 2'd0;
      c       = last;
      for (int i = 0; i < 3; i++) begin
         c = (c == 2'd2) ? 2'd0 : c + 2'd1;
         if (!p.found && req[c]) begin
            p.found = 1'b1;
            p.idx   = c;
         end
      end
      return p;
   endfunction

   function automatic logic [1:0] sel_code(input logic [1:0] idx);
      case (idx)
         2'd0:    return SEL_D0;
         2'd1:    return SEL_D1;
         default: return SEL_D2;
      endcase
   endfunction

   function automatic state_t grant_state(input logic [1:0] idx);
      case (idx)
         2'd0:    return G0;
         2'd1:    return G1;
         default: return G2;
      endcase
   endfunction

   // Source index owned by a grant state (IDLE maps to 0, callers gate on state).
   function automatic logic [1:0] state_idx(input state_t st);
      case (st)
         G1:      return 2'd1;
         G2:      return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mux3_rr_sel_if.sv
// Purpose : request/grant bundle between a requester side and mux3_rr_sel.
// Latency : n/a (wires only).
// Backpr. : ack from the consumer ends a grant early; en gates new grants.
// Signals : en, req[2:0], ack (into arbiter); s[1:0], valid, grant[2:0] (out of arbiter).
interface mux3_rr_sel_if;
   logic       en;
   logic [2:0] req;
   logic       ack;
   logic [1:0] s;
   logic       valid;
   logic [2:0] grant;

   // master: drives requests and ack; slave: the arbiter.
   modport master (output en, output req, output ack,
                   input  s,  input  valid, input grant);
   modport slave  (input  en, input  req, input  ack,
                   output s,  output valid, output grant);
endinterface

// File: rtl/mux3_rr_hold_cnt.sv
// Purpose : dwell counter for one grant; flags the final permitted cycle.
// Latency : last_cycle is decoded from the registered count (no input paths).
// Backpr. : none; saturates at HOLD_CYCLES-1 so it never wraps inside a grant.
// Ports   : clk, reset (sync, active-high), clr, inc, last_cycle.
module mux3_rr_hold_cnt #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic last_cycle
);
   localparam int CNT_W = ($clog2(HOLD_CYCLES) > 0) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_cycle = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mux3_rr_sel.sv
// Purpose : round-robin select sequencer driving the 2-bit select of a 3:1 mux.
// Latency : 1 cycle from sampled req to valid/s/grant; all outputs registered.
// Backpr. : ack or a dropped req ends a grant early; en=0 blocks new grants only.
// Ports   : clk, reset (sync, active-high), bus (slave: en, req, ack -> s, valid, grant).
// Option  : MUX3_RR_SEL_PARK_EN keeps s at the last granted code while idle.
module mux3_rr_sel
   import mux3_rr_sel_pkg::*;
#(
   parameter int HOLD_CYCLES = 4
) (
   input  logic           clk,
   input  logic           reset,
   mux3_rr_sel_if.slave   bus
);
   state_t     state_q, state_d;
   logic [1:0] last_q,  last_d;
   logic [1:0] s_q,     s_d;
   logic       valid_q, valid_d;
   logic [2:0] grant_q, grant_d;

   logic       cnt_clr;
   logic       cnt_inc;
   logic       last_cycle;
   logic       release_now;
   logic [1:0] cur_idx;
   pick_t      pick;

   mux3_rr_hold_cnt #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_cnt (
      .clk        (clk),
      .reset      (reset),
      .clr        (cnt_clr),
      .inc        (cnt_inc),
      .last_cycle (last_cycle)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cnt_clr     = 1'b1;
      cnt_inc     = 1'b0;
      release_now = 1'b0;
      cur_idx     = state_idx(state_q);
      pick        = next_req(last_q, bus.req);

      if (state_q == IDLE) begin
         if (bus.en && pick.found) begin
            state_d = grant_state(pick.idx);
         end
      end else begin
         // All release causes merge into one event.
         release_now = last_cycle | bus.ack | ~bus.req[cur_idx];
         if (release_now) begin
            last_d  = cur_idx;
            // Search from the releasing source so the hand-off skips the idle bubble.
            pick    = next_req(cur_idx, bus.req);
            state_d = (bus.en && pick.found) ? grant_state(pick.idx) : IDLE;
         end else begin
            cnt_clr = 1'b0;
            cnt_inc = 1'b1;
         end
      end

      // Outputs are decoded from the next state so they are registered alongside it.
      valid_d = (state_d != IDLE);
      grant_d = 3'b000;
      if (state_d == IDLE) begin
`ifdef MUX3_RR_SEL_PARK_EN
         s_d = s_q;
`else
         s_d = SEL_D0;
`endif
      end else begin
         s_d                       = sel_code(state_idx(state_d));
         grant_d[state_idx(state_d)] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 2'd2;
         s_q     <= SEL_D0;
         valid_q <= 1'b0;
         grant_q <= 3'b000;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         s_q     <= s_d;
         valid_q <= valid_d;
         grant_q <= grant_d;
      end
   end

   assign bus.s     = s_q;
   assign bus.valid = valid_q;
   assign bus.grant = grant_q;

endmodule

// File: tb/tb_mux3_rr_sel.sv
// Purpose : directed self-checking bench for mux3_rr_sel (HOLD_CYCLES=4 and =1).
// Latency : outputs checked 1 time unit after each rising edge.
// Backpr. : exercises ack, req drop and en=0 release paths.
module tb_mux3_rr_sel;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mux3_rr_sel_if bus_a ();
   mux3_rr_sel_if bus_b ();

   mux3_rr_sel #(.HOLD_CYCLES(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
   mux3_rr_sel #(.HOLD_CYCLES(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      bus_a.en = 1'b0; bus_a.req = 3'b000; bus_a.ack = 1'b0;
      tick;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      tick;
      checks++; if (bus_a.s !== 2'b00) begin errors++; $display("FAIL reset_s got %b exp 00", bus_a.s); end
      checks++; if (bus_a.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus_a.valid); end
      checks++; if (bus_a.grant !== 3'b000) begin errors++; $display("FAIL reset_grant got %b exp 000", bus_a.grant); end
      checks++; if (bus_b.valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid got %b exp 0", bus_b.valid); end
   endtask

   task automatic test_rotation;
      logic [1:0] exp_s;
      logic [2:0] exp_g;
      do_reset;
      bus_a.en = 1'b1; bus_a.req = 3'b111;
      for (int k = 0; k < 13; k++) begin
         tick;
         case ((k / 4) % 3)
            0:       begin exp_s = 2'b00; exp_g = 3'b001; end
            1:       begin exp_s = 2'b01; exp_g = 3'b010; end
            default: begin exp_s = 2'b10; exp_g = 3'b100; end
         endcase
         checks++; if (bus_a.s !== exp_s) begin errors++; $display("FAIL rot_s cyc %0d got %b exp %b", k, bus_a.s, exp_s); end
         checks++; if (bus_a.valid !== 1'b1) begin errors++; $display("FAIL rot_valid cyc %0d got %b exp 1", k, bus_a.valid); end
         checks++; if (bus_a.grant !== exp_g) begin errors++; $display("FAIL rot_grant cyc %0d got %b exp %b", k, bus_a.grant, exp_g); end
      end
   endtask

   task automatic test_sole_requester;
      do_reset;
      bus_a.en = 1'b1; bus_a.req = 3'b100;
      for (int k = 0; k < 10; k++) begin
         tick;
         checks++; if (bus_a.s !== 2'b10) begin errors++; $display("FAIL sole_s cyc %0d got %b exp 10", k, bus_a.s); end
         checks++; if (bus_a.valid !== 1'b1) begin errors++; $display("FAIL sole_valid cyc %0d got %b exp 1", k, bus_a.valid); end
         checks++; if (bus_a.grant !== 3'b100) begin errors++; $display("FAIL sole_grant cyc %0d got %b exp 100", k, bus_a.grant); end
      end
   endtask

   task automatic test_ack_early;
      // ack in the second G0 cycle ends the grant after 2 cycles.
      do_reset;
      bus_a.en = 1'b1; bus_a.req = 3'b111;
      tick;
      checks++; if (bus_a.s !== 2'b00) begin errors++; $display("FAIL ack_g0_first got %b exp 00", bus_a.s); end
      tick;
      checks++; if (bus_a.s !== 2'b00) begin errors++; $display("FAIL ack_g0_second got %b exp 00", bus_a.s); end
      bus_a.ack = 1'b1;
      tick;
      bus_a.ack = 1'b0;
      checks++; if (bus_a.s !== 2'b01) begin errors++; $display("FAIL ack_to_g1 got %b exp 01", bus_a.s); end
      checks++; if (bus_a.grant !== 3'b010) begin errors++; $display("FAIL ack_to_g1_grant got %b exp 010", bus_a.grant); end
      // ack together with req[0] drop: one release, then a full-length G1 grant.
      do_reset;
      bus_a.en = 1'b1; bus_a.req = 3'b111;
      tick;
      bus_a.ack = 1'b1; bus_a.req = 3'b110;
      tick;
      bus_a.ack = 1'b0; bus_a.req = 3'b111;
      checks++; if (bus_a.s !== 2'b01) begin errors++; $display("FAIL dual_rel_g1 got %b exp 01", bus_a.s); end
      checks++; if (bus_a.valid !== 1'b1) begin errors++; $display("FAIL dual_rel_valid got %b exp 1", bus_a.valid); end
      for (int k = 0; k < 3; k++) begin
         tick;
         checks++; if (bus_a.s !== 2'b01) begin errors++; $display("FAIL dual_rel_hold cyc %0d got %b exp 01", k, bus_a.s); end
      end
      tick;
      checks++; if (bus_a.s !== 2'b10) begin errors++; $display("FAIL dual_rel_next got %b exp 10", bus_a.s); end
   endtask

   task automatic test_reset_mid_grant;
      do_reset;
      bus_a.en = 1'b1; bus_a.req = 3'b111;
      repeat (5) tick;
      checks++; if (bus_a.s !== 2'b01) begin errors++; $display("FAIL mid_pre_g1 got %b exp 01", bus_a.s); end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      checks++; if (bus_a.s !== 2'b00) begin errors++; $display("FAIL mid_rst_s got %b exp 00", bus_a.s); end
      checks++; if (bus_a.valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", bus_a.valid); end
      checks++; if (bus_a.grant !== 3'b000) begin errors++; $display("FAIL mid_rst_grant got %b exp 000", bus_a.grant); end
      tick;
      checks++; if (bus_a.grant !== 3'b001) begin errors++; $display("FAIL mid_first_g0 got %b exp 001", bus_a.grant); end
      checks++; if (bus_a.valid !== 1'b1) begin errors++; $display("FAIL mid_first_valid got %b exp 1", bus_a.valid); end
   endtask

   task automatic test_en_off;
      logic [1:0] park_s;
`ifdef MUX3_RR_SEL_PARK_EN
      park_s = 2'b10;
`else
      park_s = 2'b00;
`endif
      do_reset;
      bus_a.en = 1'b1; bus_a.req = 3'b111;
      tick;
      bus_a.en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         checks++; if (bus_a.valid !== 1'b1) begin errors++; $display("FAIL enoff_run cyc %0d got %b exp 1", k, bus_a.valid); end
         checks++; if (bus_a.s !== 2'b00) begin errors++; $display("FAIL enoff_run_s cyc %0d got %b exp 00", k, bus_a.s); end
      end
      tick;
      checks++; if (bus_a.valid !== 1'b0) begin errors++; $display("FAIL enoff_idle_valid got %b exp 0", bus_a.valid); end
      checks++; if (bus_a.grant !== 3'b000) begin errors++; $display("FAIL enoff_idle_grant got %b exp 000", bus_a.grant); end
      checks++; if (bus_a.s !== 2'b00) begin errors++; $display("FAIL enoff_idle_s got %b exp 00", bus_a.s); end
      // ack while idle has no effect.
      bus_a.ack = 1'b1;
      tick;
      bus_a.ack = 1'b0;
      tick;
      checks++; if (bus_a.valid !== 1'b0) begin errors++; $display("FAIL idle_ack_valid got %b exp 0", bus_a.valid); end
      // Same from G2: the parked code differs from 00 only with the option.
      do_reset;
      bus_a.en = 1'b1; bus_a.req = 3'b100;
      tick;
      bus_a.en = 1'b0;
      repeat (3) tick;
      checks++; if (bus_a.s !== 2'b10) begin errors++; $display("FAIL enoff_g2_run got %b exp 10", bus_a.s); end
      tick;
      checks++; if (bus_a.valid !== 1'b0) begin errors++; $display("FAIL enoff_g2_valid got %b exp 0", bus_a.valid); end
      checks++; if (bus_a.s !== park_s) begin errors++; $display("FAIL enoff_g2_park got %b exp %b", bus_a.s, park_s); end
      tick;
      checks++; if (bus_a.s !== park_s) begin errors++; $display("FAIL enoff_g2_park2 got %b exp %b", bus_a.s, park_s); end
      bus_a.en = 1'b1;
      tick;
      checks++; if (bus_a.s !== 2'b10) begin errors++; $display("FAIL enoff_regrant got %b exp 10", bus_a.s); end
      checks++; if (bus_a.valid !== 1'b1) begin errors++; $display("FAIL enoff_regrant_valid got %b exp 1", bus_a.valid); end
   endtask

   task automatic test_hold_one;
      logic [1:0] exp_s;
      do_reset;
      bus_b.en = 1'b1; bus_b.req = 3'b101;
      for (int k = 0; k < 8; k++) begin
         tick;
         exp_s = (k % 2 == 0) ? 2'b00 : 2'b10;
         checks++; if (bus_b.s !== exp_s) begin errors++; $display("FAIL hold1_s cyc %0d got %b exp %b", k, bus_b.s, exp_s); end
         checks++; if (bus_b.valid !== 1'b1) begin errors++; $display("FAIL hold1_valid cyc %0d got %b exp 1", k, bus_b.valid); end
      end
      bus_b.en = 1'b0; bus_b.req = 3'b000;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus_a.en = 1'b0; bus_a.req = 3'b000; bus_a.ack = 1'b0;
      bus_b.en = 1'b0; bus_b.req = 3'b000; bus_b.ack = 1'b0;
      test_reset;
      test_rotation;
      test_sole_requester;
      test_ack_early;
      test_reset_mid_grant;
      test_en_off;
      test_hold_one;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
